uart_tx_sched: RTL and testbench

- Front-end controller for the UART TX peripheral. Accepts bytes from two requesters (req0 = CPU path, req1 = debug/trace path), arbitrates round-robin into a shared TX FIFO, and sequences the uart_tx register interface.
- For each byte: data write to 0x0111, start write to 0x0110, wait for irq, pulse ack.
- Sits between the bus-side producers and the uart_tx instance, replacing direct software sequencing.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_tx_fifo.sv | 49 ++++
 rtl/uart_tx_sched.sv | 137 +++++++++++++
 tb/tb_uart_tx_sched.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared uart_tx register map and scheduler state encoding.
package uart_pkg;

   localparam logic [15:0] UART_DATA_ADDR = 16'h0111;
   localparam logic [15:0] UART_CTRL_ADDR = 16'h0110;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_START = 3'd2,
      ST_WAIT  = 3'd3,
      ST_ACK   = 3'd4
   } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO with wrap-around pointers; pushes while full and pops while empty are dropped.
module uart_tx_fifo #(
   parameter int DEPTH = 8,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [7:0]   push_data,
   input  logic         pop,
   output logic [7:0]   pop_data,
   output logic         full,
   output logic         empty,
   output logic [AW:0]  count
);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push_ok;
   logic          pop_ok;

   assign full     = (count == (AW+1)'(DEPTH));
   assign empty    = (count == '0);
   assign push_ok  = push & ~full;
   assign pop_ok   = pop & ~empty;
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin merge of two byte requesters into a TX FIFO, then per-byte
// sequencing of the uart_tx register interface (data, start, wait irq, ack).
//
// state    | meaning
// ST_IDLE  | tx_addr=0; pop head of FIFO when non-empty
// ST_LOAD  | drive DATA_ADDR with the popped byte
// ST_START | drive CTRL_ADDR with 0; arm watchdog
// ST_WAIT  | wait for tx_irq or watchdog terminal count
// ST_ACK   | one-cycle tx_ack pulse
module uart_tx_sched
   import uart_pkg::*;
#(
   parameter int          DEPTH       = 8,
   parameter logic [15:0] DATA_ADDR   = UART_DATA_ADDR,
   parameter logic [15:0] CTRL_ADDR   = UART_CTRL_ADDR,
   parameter int          TIMEOUT_CYC = 131072
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req0_valid,
   input  logic [7:0]             req0_data,
   output logic                   req0_ready,
   input  logic                   req1_valid,
   input  logic [7:0]             req1_data,
   output logic                   req1_ready,
   output logic [15:0]            tx_addr,
   output logic [7:0]             tx_data,
   output logic                   tx_ack,
   input  logic                   tx_irq,
   output logic                   busy,
   output logic [$clog2(DEPTH):0] fifo_count,
   output logic                   timeout_err
);

   localparam int            WW      = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [WW-1:0] WD_LOAD = WW'(TIMEOUT_CYC - 1);

   tx_state_e     state;
   logic [WW-1:0] wd_cnt;
   logic          arb_en;
   logic          rr_ptr;
   logic          grant0;
   logic          grant1;
   logic          push;
   logic [7:0]    push_data;
   logic          pop;
   logic [7:0]    pop_data;
   logic          full;
   logic          empty;

   // rr_ptr=0 favours req0; readys stay low until the first clock after reset
   assign grant0     = req0_valid & (~req1_valid | ~rr_ptr);
   assign grant1     = req1_valid & (~req0_valid | rr_ptr);
   assign req0_ready = arb_en & grant0 & ~full;
   assign req1_ready = arb_en & grant1 & ~full;
   assign push       = req0_ready | req1_ready;
   assign push_data  = grant0 ? req0_data : req1_data;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         arb_en <= 1'b0;
         rr_ptr <= 1'b0;
      end else begin
         arb_en <= 1'b1;
         if (push & req0_valid & req1_valid) rr_ptr <= ~rr_ptr;
      end
   end

   uart_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .pop_data  (pop_data),
      .full      (full),
      .empty     (empty),
      .count     (fifo_count)
   );

   assign pop  = (state == ST_IDLE) & ~empty;
   assign busy = (state != ST_IDLE) | ~empty;

   // Outputs are registered on the transition so they line up with the state they belong to.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= ST_IDLE;
         wd_cnt      <= '0;
         tx_addr     <= 16'h0000;
         tx_data     <= 8'h00;
         tx_ack      <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         tx_ack <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (!empty) begin
                  state   <= ST_LOAD;
                  tx_addr <= DATA_ADDR;
                  tx_data <= pop_data;
               end
            end
            ST_LOAD: begin
               state   <= ST_START;
               tx_addr <= CTRL_ADDR;
               tx_data <= 8'h00;
            end
            ST_START: begin
               state   <= ST_WAIT;
               tx_addr <= 16'h0000;
               wd_cnt  <= WD_LOAD;
            end
            ST_WAIT: begin
               if (tx_irq) begin
                  state  <= ST_ACK;
                  tx_ack <= 1'b1;
               end else if (wd_cnt == '0) begin
                  state       <= ST_ACK;
                  tx_ack      <= 1'b1;
                  timeout_err <= 1'b1;
               end else begin
                  wd_cnt <= wd_cnt - WW'(1);
               end
            end
            ST_ACK: begin
               state <= ST_IDLE;
            end
            default: begin
               state   <= ST_IDLE;
               tx_addr <= 16'h0000;
               tx_data <= 8'h00;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: random and directed traffic against a timeline model
// of byte acceptance, FIFO order and the per-byte register sequence.
module tb_uart_tx_sched;
   import uart_pkg::*;

   localparam int DEPTH = 8;
   localparam int T     = 100;
   localparam int NEVER = -100000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req0_valid = 1'b0, req1_valid = 1'b0;
   logic [7:0]  req0_data = '0, req1_data = '0;
   logic        req0_ready, req1_ready;
   logic [15:0] tx_addr;
   logic [7:0]  tx_data;
   logic        tx_ack;
   logic        tx_irq = 1'b0;
   logic        busy;
   logic [3:0]  fifo_count;
   logic        timeout_err;

   always #5 clk = ~clk;

   uart_tx_sched #(.DEPTH(DEPTH), .TIMEOUT_CYC(T)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
      .tx_addr(tx_addr), .tx_data(tx_data), .tx_ack(tx_ack), .tx_irq(tx_irq),
      .busy(busy), .fifo_count(fifo_count), .timeout_err(timeout_err)
   );

   int n_chk = 0;
   int n_fail = 0;

   // model: queued bytes plus the timeline of the byte currently being sent
   logic [7:0] mq[$];
   logic [7:0] acc_log[$];
   int         c, t_load, t_start, t_wait, t_ack, t_free, d_cur, err_time;
   logic [7:0] cur_b;
   bit         m_rr, noise;
   int         irq_mode, fixed_d;
   logic       drv_v0, drv_v1;
   logic [7:0] drv_d0, drv_d1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      c = 0; t_load = NEVER; t_start = NEVER; t_wait = NEVER; t_ack = NEVER;
      t_free = 0; d_cur = 0; err_time = 1 << 30; m_rr = 1'b0; noise = 1'b0; cur_b = '0;
      drv_v0 = 1'b0; drv_v1 = 1'b0; drv_d0 = '0; drv_d1 = '0;
   endtask

   function automatic int pick_delay();
      if (irq_mode == 1) return fixed_d;
      if (irq_mode == 2) return T + 1000;
      if ($urandom_range(0, 9) == 0) return T + 5;
      return int'($urandom_range(0, 40));
   endfunction

   task automatic step();
      bit   idle, full;
      int   gnt;
      logic [15:0] e_addr;
      @(negedge clk);
      idle   = (c >= t_free);
      e_addr = (c == t_load) ? UART_DATA_ADDR : (c == t_start) ? UART_CTRL_ADDR : 16'h0000;
      chk("tx_addr", 32'(tx_addr), 32'(e_addr));
      if (c == t_load)  chk("tx_data_load", 32'(tx_data), 32'(cur_b));
      if (c == t_start) chk("tx_data_start", 32'(tx_data), 32'h0);
      chk("tx_ack", 32'(tx_ack), 32'(c == t_ack));
      chk("timeout_err", 32'(timeout_err), 32'(c >= err_time));
      chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
      chk("busy", 32'(busy), 32'(!idle || mq.size() != 0));
      req0_valid = drv_v0; req0_data = drv_d0;
      req1_valid = drv_v1; req1_data = drv_d1;
      tx_irq = ((c >= t_wait + d_cur) && (c <= t_ack)) || (noise && c == t_start);
      #1;
      full = (mq.size() == DEPTH);
      if (drv_v0 && drv_v1) gnt = m_rr ? 1 : 0;
      else if (drv_v0)      gnt = 0;
      else if (drv_v1)      gnt = 1;
      else                  gnt = -1;
      chk("req0_ready", 32'(req0_ready), 32'(gnt == 0 && !full));
      chk("req1_ready", 32'(req1_ready), 32'(gnt == 1 && !full));
      if (idle && mq.size() > 0) begin
         cur_b   = mq.pop_front();
         t_load  = c + 1;
         t_start = c + 2;
         t_wait  = c + 3;
         d_cur   = pick_delay();
         t_ack   = t_wait + ((d_cur < T) ? d_cur : T - 1) + 1;
         t_free  = t_ack + 1;
         if (d_cur >= T && err_time > t_ack) err_time = t_ack;
         noise   = ($urandom_range(0, 1) == 1);
      end
      if (gnt >= 0 && !full) begin
         mq.push_back(gnt == 0 ? drv_d0 : drv_d1);
         acc_log.push_back(gnt == 0 ? drv_d0 : drv_d1);
         if (drv_v0 && drv_v1) m_rr = !m_rr;
      end
      c++;
   endtask

   task automatic drain(input int budget);
      drv_v0 = 1'b0; drv_v1 = 1'b0;
      for (int i = 0; i < budget && !(c >= t_free && mq.size() == 0); i++) step();
      step();
      chk("drain_idle_busy", 32'(busy), 32'h0);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_addr"},  32'(tx_addr), 32'h0);
      chk({tag, "_data"},  32'(tx_data), 32'h0);
      chk({tag, "_ack"},   32'(tx_ack), 32'h0);
      chk({tag, "_err"},   32'(timeout_err), 32'h0);
      chk({tag, "_count"}, 32'(fifo_count), 32'h0);
      chk({tag, "_busy"},  32'(busy), 32'h0);
      chk({tag, "_rdy0"},  32'(req0_ready), 32'h0);
      chk({tag, "_rdy1"},  32'(req1_ready), 32'h0);
   endtask

   initial begin
      int base, n_acc;
      model_reset();
      irq_mode = 0; fixed_d = 10;

      // power-on reset with both requesters asserting
      req0_valid = 1'b1; req1_valid = 1'b1;
      #23;
      check_reset_outputs("por");
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge clk); #2; rst = 1'b1;

      // single byte from req0
      irq_mode = 1; fixed_d = 25;
      drv_v0 = 1'b1; drv_d0 = 8'hA9;
      step();
      drv_v0 = 1'b0;
      drain(200);

      // contention: both requesters continuously valid
      irq_mode = 0;
      base = acc_log.size();
      drv_v0 = 1'b1; drv_d0 = 8'h27; drv_v1 = 1'b1; drv_d1 = 8'h53;
      for (int i = 0; i < 14; i++) step();
      for (int i = base; i < acc_log.size(); i++)
         chk("contention_order", 32'(acc_log[i]), ((i - base) % 2 == 0) ? 32'h27 : 32'h53);
      drain(3000);

      // back-to-back drain of three queued bytes, irq after 10 cycles each
      irq_mode = 1; fixed_d = 10;
      drv_v1 = 1'b1;
      for (int i = 0; i < 3; i++) begin drv_d1 = 8'(8'hC0 + i); step(); end
      drain(300);

      // random traffic
      irq_mode = 0;
      for (int i = 0; i < 400; i++) begin
         drv_v0 = ($urandom_range(0, 2) == 0); drv_d0 = 8'($urandom);
         drv_v1 = ($urandom_range(0, 2) == 0); drv_d1 = 8'($urandom);
         step();
      end
      drain(4000);

      // fill with irq held low: first byte times out, FIFO caps at DEPTH
      irq_mode = 2;
      base = acc_log.size();
      drv_v0 = 1'b1;
      for (int i = 0; i < 14; i++) begin drv_d0 = 8'($urandom); step(); end
      n_acc = acc_log.size() - base;
      chk("full_accepted", 32'(n_acc), 32'(DEPTH + 1));
      chk("full_count", 32'(fifo_count), 32'(DEPTH));
      chk("full_ready0", 32'(req0_ready), 32'h0);
      drv_v0 = 1'b0;
      irq_mode = 0;
      drain(3000);
      chk("timeout_sticky", 32'(timeout_err), 32'h1);

      // reset in the middle of WAIT with bytes still queued
      irq_mode = 2;
      drv_v0 = 1'b1;
      for (int i = 0; i < 3; i++) begin drv_d0 = 8'($urandom); step(); end
      drv_v0 = 1'b0;
      for (int i = 0; i < 40 && c < t_wait + 5; i++) step();
      chk("pre_reset_count", 32'(fifo_count), 32'h2);
      @(negedge clk); #2;
      tx_irq = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
      rst = 1'b0;
      #1;
      check_reset_outputs("midrst");
      @(negedge clk); @(negedge clk);
      req0_valid = 1'b0; req1_valid = 1'b0;
      #2; rst = 1'b1;
      model_reset();
      for (int i = 0; i < 4; i++) step();
      chk("post_reset_busy", 32'(busy), 32'h0);

      // block works normally after reset
      irq_mode = 1; fixed_d = 7;
      drv_v1 = 1'b1; drv_d1 = 8'h5A;
      step();
      drain(200);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
